// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul register bank: region offsets,
// CTRL bit positions, FSM state encoding and the address decoder.
package matmul_pkg;

    localparam logic [4:0] CTRL_ADDR  = 5'h00;
    localparam logic [4:0] A_ADDR     = 5'h04;
    localparam logic [4:0] B_ADDR     = 5'h08;
    localparam logic [4:0] FLAGS_ADDR = 5'h0C;
    localparam logic [4:0] SP_ADDR    = 5'h10;

    localparam int START_BIT = 0;
    localparam int DONE_BIT  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_CTRL,
        REG_A,
        REG_B,
        REG_FLAGS,
        REG_SP
    } region_e;

    // Offsets between the named registers that are not SP decode to
    // REG_NONE: they read as zero and swallow writes.
    function automatic region_e decode_region(input logic [4:0] off);
        region_e r;
        r = REG_NONE;
        unique case (1'b1)
            (off >= SP_ADDR):     r = REG_SP;
            (off == CTRL_ADDR):   r = REG_CTRL;
            (off == A_ADDR):      r = REG_A;
            (off == B_ADDR):      r = REG_B;
            (off == FLAGS_ADDR):  r = REG_FLAGS;
            default:              r = REG_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/matmul_reg_bank_if.sv
// Host-side bus between the APB slave and the register bank.
// master: the APB slave; slave: matmul_reg_bank.
interface matmul_reg_bank_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int BUS_WIDTH  = 64,
    parameter int MAX_DIM    = 2
);
    logic [ADDR_WIDTH-1:0] address;
    logic [BUS_WIDTH-1:0]  wr_data;
    logic [MAX_DIM-1:0]    strobe;
    logic [BUS_WIDTH-1:0]  rd_data;
    logic                  start_bit;

    modport master (
        output address,
        output wr_data,
        output strobe,
        input  rd_data,
        input  start_bit
    );

    modport slave (
        input  address,
        input  wr_data,
        input  strobe,
        output rd_data,
        output start_bit
    );
endinterface

// File: rtl/matmul_buffer.sv
// DEPTH x BUS_WIDTH word buffer with per-element strobed writes and
// N_RD combinational read ports. Ports: clk_i, rst_ni, wr_idx,
// wr_data, wr_strb (one bit per element), rd_idx[N_RD], rd_data[N_RD].
module matmul_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 64,
    parameter int DEPTH      = 4,
    parameter int N_RD       = 1,
    localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [IDX_W-1:0]                wr_idx,
    input  logic [BUS_WIDTH-1:0]            wr_data,
    input  logic [MAX_DIM-1:0]              wr_strb,
    input  logic [N_RD-1:0][IDX_W-1:0]      rd_idx,
    output logic [N_RD-1:0][BUS_WIDTH-1:0]  rd_data
);

    logic [BUS_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int n = 0; n < MAX_DIM; n++) begin
                if (wr_strb[n]) begin
                    mem[wr_idx][n*DATA_WIDTH +: DATA_WIDTH]
                        <= wr_data[n*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    for (genvar p = 0; p < N_RD; p++) begin : g_rd
        assign rd_data[p] = mem[rd_idx[p]];
    end

endmodule

// File: rtl/matmul_reg_bank.sv
// Register/operand bank for the matmul accelerator: A/B operand and SP
// result buffers, CTRL/FLAGS and the start/run/done engine handshake.
// Ports: clk_i, rst_ni, bus (host slave modport), eng_* engine side.
module matmul_reg_bank
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    matmul_reg_bank_if.slave      bus,
    output logic                  eng_start_o,
    input  logic [IDX_W-1:0]      eng_rd_idx_i,
    output logic [BUS_WIDTH-1:0]  eng_a_o,
    output logic [BUS_WIDTH-1:0]  eng_b_o,
    input  logic                  eng_wr_en_i,
    input  logic [IDX_W-1:0]      eng_wr_idx_i,
    input  logic [BUS_WIDTH-1:0]  eng_wr_data_i,
    input  logic [DATA_WIDTH-1:0] eng_flags_i,
    input  logic                  eng_done_i
);

    region_e              region;
    logic [IDX_W-1:0]     host_idx;
    logic                 host_wr;
    logic                 start_wr;
    logic [MAX_DIM-1:0]   a_strb;
    logic [MAX_DIM-1:0]   b_strb;
    logic [MAX_DIM-1:0]   sp_strb;

    logic [1:0][BUS_WIDTH-1:0] a_rd;
    logic [1:0][BUS_WIDTH-1:0] b_rd;
    logic [0:0][BUS_WIDTH-1:0] sp_rd;

    state_e               state;
    logic                 start_bit;
    logic                 eng_start;
    logic                 done;
    logic [DATA_WIDTH-1:0] flags;

    logic unused_addr;
    assign unused_addr = ^bus.address[ADDR_WIDTH-1:5+IDX_W];

    assign region   = decode_region(bus.address[4:0]);
    assign host_idx = bus.address[5 +: IDX_W];
    assign host_wr  = |bus.strobe;

    assign a_strb  = (region == REG_A) ? bus.strobe : '0;
    assign b_strb  = (region == REG_B) ? bus.strobe : '0;
    assign sp_strb = {MAX_DIM{eng_wr_en_i}};

    // Only element 0 carries CTRL; writing 0 never stops the engine.
    assign start_wr = host_wr && (region == REG_CTRL)
                   && bus.strobe[0] && bus.wr_data[START_BIT];

    matmul_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUS_WIDTH  (BUS_WIDTH),
        .DEPTH      (DEPTH),
        .N_RD       (2)
    ) u_buf_a (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .wr_idx  (host_idx),
        .wr_data (bus.wr_data),
        .wr_strb (a_strb),
        .rd_idx  ({eng_rd_idx_i, host_idx}),
        .rd_data (a_rd)
    );

    matmul_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUS_WIDTH  (BUS_WIDTH),
        .DEPTH      (DEPTH),
        .N_RD       (2)
    ) u_buf_b (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .wr_idx  (host_idx),
        .wr_data (bus.wr_data),
        .wr_strb (b_strb),
        .rd_idx  ({eng_rd_idx_i, host_idx}),
        .rd_data (b_rd)
    );

    // SP is written only by the engine; the host path is read-only.
    matmul_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUS_WIDTH  (BUS_WIDTH),
        .DEPTH      (DEPTH),
        .N_RD       (1)
    ) u_buf_sp (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .wr_idx  (eng_wr_idx_i),
        .wr_data (eng_wr_data_i),
        .wr_strb (sp_strb),
        .rd_idx  (host_idx),
        .rd_data (sp_rd)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ST_IDLE;
            start_bit <= 1'b0;
            eng_start <= 1'b0;
            done      <= 1'b0;
            flags     <= '0;
        end else begin
            eng_start <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_wr) begin
                        state     <= ST_RUN;
                        start_bit <= 1'b1;
                        eng_start <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (eng_done_i) begin
                        state     <= ST_DONE;
                        start_bit <= 1'b0;
                        done      <= 1'b1;
                        flags     <= eng_flags_i;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.rd_data = '0;
        unique case (region)
            REG_CTRL: begin
                bus.rd_data[START_BIT] = start_bit;
                bus.rd_data[DONE_BIT]  = done;
            end
            REG_A:     bus.rd_data = a_rd[0];
            REG_B:     bus.rd_data = b_rd[0];
            REG_FLAGS: bus.rd_data[DATA_WIDTH-1:0] = flags;
            REG_SP:    bus.rd_data = sp_rd[0];
            default:   bus.rd_data = '0;
        endcase
    end

    assign bus.start_bit = start_bit;
    assign eng_start_o   = eng_start;
    assign eng_a_o       = a_rd[1];
    assign eng_b_o       = b_rd[1];

endmodule
